// File: rtl/gcm_pkg.sv
// rtl/gcm_pkg.sv - shared types and default timing constants for the GCM sequencer
// Purpose: command encoding, sequencer state encoding and default hazard gaps.
// Contents:
//   gcm_cmd_e        - command word type carried on cmd_type_i (6..7 unused, illegal)
//   gcm_seq_state_e  - sequencer message-order states
//   *_DEF            - default KEY_WAIT / H_WAIT / DONE_TIMEOUT values
package gcm_pkg;

  typedef enum logic [2:0] {
    CMD_KEY  = 3'd0,
    CMD_IV   = 3'd1,
    CMD_AAD  = 3'd2,
    CMD_DATA = 3'd3,
    CMD_TAG  = 3'd4,
    CMD_END  = 3'd5
  } gcm_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_SETTLE,
    ST_KEYED,
    ST_IV_SETTLE,
    ST_AAD,
    ST_DATA,
    ST_TAG_SENT,
    ST_END_WAIT
  } gcm_seq_state_e;

  localparam int KEY_WAIT_DEF     = 12;
  localparam int H_WAIT_DEF       = 24;
  localparam int DONE_TIMEOUT_DEF = 64;

endpackage

// File: rtl/gcm_seq_ctrl.sv
// rtl/gcm_seq_ctrl.sv - command sequencer enforcing GCM message order and hazard gaps
// Purpose: accepts typed 128-bit command words, rejects out-of-order ones, waits out
//   key-expansion and H/J0 settle times, issues one-cycle strobes to the gcm datapath
//   and turns the datapath's tag/auth responses into a per-message completion status.
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   cmd_vld_i/cmd_rdy_o             - command handshake
//   cmd_type_i/cmd_decrypt_i/cmd_data_i - command type, direction (taken with IV), word
//   gcm_en_o/gcm_decrypt_o          - message active, latched direction
//   gcm_*_vld_o, gcm_end_o          - one-cycle datapath strobes
//   gcm_key_o/gcm_data_o            - key word / IV-AAD-data-tag word (held between strobes)
//   gcm_tag_vld_i/gcm_ok_vld_i/gcm_ok_i - datapath responses
//   busy_o/done_o/auth_ok_o/err_o   - status
module gcm_seq_ctrl
  import gcm_pkg::*;
#(
  parameter int KEY_WAIT     = KEY_WAIT_DEF,
  parameter int H_WAIT       = H_WAIT_DEF,
  parameter int DONE_TIMEOUT = DONE_TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_vld_i,
  output logic         cmd_rdy_o,
  input  logic [2:0]   cmd_type_i,
  input  logic         cmd_decrypt_i,
  input  logic [127:0] cmd_data_i,
  output logic         gcm_en_o,
  output logic         gcm_decrypt_o,
  output logic         gcm_key_vld_o,
  output logic         gcm_iv_vld_o,
  output logic         gcm_aad_vld_o,
  output logic         gcm_data_vld_o,
  output logic         gcm_tag_vld_o,
  output logic         gcm_end_o,
  output logic [127:0] gcm_key_o,
  output logic [127:0] gcm_data_o,
  input  logic         gcm_tag_vld_i,
  input  logic         gcm_ok_vld_i,
  input  logic         gcm_ok_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         auth_ok_o,
  output logic         err_o
);

  // Terminal counter values: a settle state lasts exactly WAIT cycles (count 0..WAIT-1).
  localparam logic [7:0] KEY_T = 8'(KEY_WAIT - 1);
  localparam logic [7:0] H_T   = 8'(H_WAIT - 1);
  localparam logic [7:0] TO_T  = 8'(DONE_TIMEOUT - 1);

  gcm_seq_state_e state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           tag_seen_q, tag_seen_d;
  logic           rdy_q, dec_q, en_q;

  logic legal, issue, bad, tag_hit, resolve, timeout;

  // State register with the shared wait counter and the decrypt tag-seen flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      tag_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tag_seen_q <= tag_seen_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_KEYED: begin
        if (issue) state_d = (cmd_type_i == CMD_KEY) ? ST_KEY_SETTLE : ST_IV_SETTLE;
      end
      ST_KEY_SETTLE: if (cnt_q == KEY_T) state_d = ST_KEYED;
      ST_IV_SETTLE:  if (cnt_q == H_T)   state_d = ST_AAD;
      ST_AAD, ST_DATA: begin
        if (issue) begin
          case (cmd_type_i)
            CMD_DATA: state_d = ST_DATA;
            CMD_TAG:  state_d = ST_TAG_SENT;
            CMD_END:  state_d = ST_END_WAIT;
            default:  state_d = state_q;
          endcase
        end
      end
      ST_TAG_SENT: if (issue) state_d = ST_END_WAIT;
      ST_END_WAIT: if (resolve || timeout) state_d = ST_KEYED;
      default:     state_d = ST_IDLE;
    endcase

    // Counter restarts on every state change; in END_WAIT it freezes once the tag is
    // in, since from then on only the auth result is awaited.
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = 8'd0;
    end else if (state_q == ST_KEY_SETTLE || state_q == ST_IV_SETTLE ||
                 (state_q == ST_END_WAIT && !tag_hit)) begin
      cnt_d = cnt_q + 8'd1;
    end

    tag_seen_d = (state_q == ST_END_WAIT) && (state_d == ST_END_WAIT) && tag_hit;
  end

  // Output decode: command legality and response resolution.
  always_comb begin
    legal = 1'b0;
    case (state_q)
      ST_IDLE:     legal = (cmd_type_i == CMD_KEY);
      ST_KEYED:    legal = (cmd_type_i == CMD_KEY) || (cmd_type_i == CMD_IV);
      ST_AAD:      legal = (cmd_type_i == CMD_AAD) || (cmd_type_i == CMD_DATA) ||
                           (cmd_type_i == CMD_END && !dec_q) ||
                           (cmd_type_i == CMD_TAG && dec_q);
      ST_DATA:     legal = (cmd_type_i == CMD_DATA) ||
                           (cmd_type_i == CMD_END && !dec_q) ||
                           (cmd_type_i == CMD_TAG && dec_q);
      ST_TAG_SENT: legal = (cmd_type_i == CMD_END);
      default:     legal = 1'b0;
    endcase
    issue   = cmd_vld_i && rdy_q && legal;
    bad     = cmd_vld_i && rdy_q && !legal;
    tag_hit = tag_seen_q || gcm_tag_vld_i;
    // Decrypt completes when the auth result arrives with or after the tag.
    resolve = (state_q == ST_END_WAIT) &&
              (dec_q ? (tag_hit && gcm_ok_vld_i) : gcm_tag_vld_i);
    // A tag in the terminal cycle wins over the timeout.
    timeout = (state_q == ST_END_WAIT) && !tag_hit && (cnt_q == TO_T);
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy_q          <= 1'b0;
      dec_q          <= 1'b0;
      en_q           <= 1'b0;
      gcm_key_vld_o  <= 1'b0;
      gcm_iv_vld_o   <= 1'b0;
      gcm_aad_vld_o  <= 1'b0;
      gcm_data_vld_o <= 1'b0;
      gcm_tag_vld_o  <= 1'b0;
      gcm_end_o      <= 1'b0;
      gcm_key_o      <= '0;
      gcm_data_o     <= '0;
      done_o         <= 1'b0;
      auth_ok_o      <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      rdy_q          <= !(state_d == ST_KEY_SETTLE || state_d == ST_IV_SETTLE ||
                          state_d == ST_END_WAIT);
      gcm_key_vld_o  <= issue && (cmd_type_i == CMD_KEY);
      gcm_iv_vld_o   <= issue && (cmd_type_i == CMD_IV);
      gcm_aad_vld_o  <= issue && (cmd_type_i == CMD_AAD);
      gcm_data_vld_o <= issue && (cmd_type_i == CMD_DATA);
      gcm_tag_vld_o  <= issue && (cmd_type_i == CMD_TAG);
      gcm_end_o      <= issue && (cmd_type_i == CMD_END);
      if (issue && cmd_type_i == CMD_KEY) gcm_key_o <= cmd_data_i;
      if (issue && (cmd_type_i == CMD_IV || cmd_type_i == CMD_AAD ||
                    cmd_type_i == CMD_DATA || cmd_type_i == CMD_TAG))
        gcm_data_o <= cmd_data_i;
      if (issue && cmd_type_i == CMD_IV) begin
        dec_q <= cmd_decrypt_i;
        en_q  <= 1'b1;
      end else if (resolve || timeout) begin
        en_q  <= 1'b0;
      end
      done_o    <= resolve;
      auth_ok_o <= resolve && (dec_q ? gcm_ok_i : 1'b1);
      err_o     <= bad || timeout;
    end
  end

  assign cmd_rdy_o     = rdy_q;
  assign gcm_en_o      = en_q;
  assign gcm_decrypt_o = dec_q;
  assign busy_o        = !(state_q == ST_IDLE || state_q == ST_KEYED);

endmodule

// File: doc/gcm_seq_ctrl.md
# gcm_seq_ctrl

Command sequencer in front of the `gcm` datapath. It accepts a single ready/valid command stream of typed 128-bit words (KEY, IV, AAD, DATA, TAG, END) and enforces legal message order. It also enforces the datapath's hazard gaps: key-expansion settle, and H/J0 computation after IV. It then issues one-cycle strobes to the datapath and collects tag and auth results into a per-message completion status.

## Interface
Parameters:
- `KEY_WAIT`, 12: cycles after a KEY strobe before an IV may issue.
- `H_WAIT`, 24: cycles after an IV strobe before the first AAD/DATA may issue (H and J0 settle).
- `DONE_TIMEOUT`, 64: maximum cycles from the END strobe to `gcm_tag_vld_i`.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset; synchronous, active-low.
- `cmd_vld_i`  in  1  command valid.
- `cmd_rdy_o`  out  1  command ready.
- `cmd_type_i`  in  3  command type, `gcm_cmd_e`.
- `cmd_decrypt_i`  in  1  message direction; sampled with IV.
- `cmd_data_i`  in  128  key / IV / AAD / data / tag word.
- `gcm_en_o`  out  1  high from IV issue to message done.
- `gcm_decrypt_o`  out  1  latched direction.
- `gcm_key_vld_o`, `gcm_iv_vld_o`, `gcm_aad_vld_o`, `gcm_data_vld_o`, `gcm_tag_vld_o`, `gcm_end_o`  out  1 each  one-cycle strobes.
- `gcm_key_o`  out  128  key word.
- `gcm_data_o`  out  128  IV / AAD / data / tag word.
- `gcm_tag_vld_i`  in  1  datapath tag valid.
- `gcm_ok_vld_i`  in  1  datapath auth-result valid.
- `gcm_ok_i`  in  1  auth result.
- `busy_o`  out  1  state is neither IDLE nor KEYED.
- `done_o`  out  1  one-cycle message-complete pulse.
- `auth_ok_o`  out  1  valid with `done_o`: decrypt → `gcm_ok_i`; encrypt → 1.
- `err_o`  out  1  one-cycle pulse: illegal command or timeout.

## Operation
- States: IDLE (no key), KEY_SETTLE, KEYED, IV_SETTLE, AAD, DATA, TAG_SENT, END_WAIT.
- One wait counter, 8 bits, shared by KEY_SETTLE, IV_SETTLE and END_WAIT.
- IDLE/KEYED:
  - KEY accepted → KEY_SETTLE for `KEY_WAIT` cycles → KEYED.
  - IV accepted only in KEYED → IV_SETTLE; latches `cmd_decrypt_i`.
  - IV_SETTLE counts `H_WAIT` cycles and then enters AAD.
- AAD state:
  - AAD accepted; stay in AAD.
  - DATA accepted → DATA state.
  - END accepted (encrypt) → END_WAIT.
  - TAG accepted (decrypt only) → TAG_SENT.
- DATA state:
  - DATA accepted; stay in DATA.
  - END (encrypt) → END_WAIT.
  - TAG (decrypt) → TAG_SENT.
  - AAD is illegal.
- TAG_SENT: only END is legal → END_WAIT.
- END_WAIT:
  - On `gcm_tag_vld_i`: encrypt → `done_o`=1, `auth_ok_o`=1, → KEYED.
  - Decrypt: waits further for `gcm_ok_vld_i`, then pulses `done_o` with `auth_ok_o`=`gcm_ok_i`, → KEYED.
- Illegal commands are consumed (ready=1), not issued, and pulse `err_o`; state is unchanged. Illegal means:
  - any wrong type for the current state;
  - TAG in encrypt;
  - END in decrypt without a prior TAG;
  - KEY or IV while busy.
- Timeout: the counter reaches `DONE_TIMEOUT` in END_WAIT → `err_o`=1, `done_o`=0, `gcm_en_o` drops, → KEYED.
- `cmd_rdy_o` is 0 in KEY_SETTLE, IV_SETTLE and END_WAIT, and 1 in all other states.
- Once the wait completes, `cmd_rdy_o` rises in the cycle after the counter hits its terminal value.

## Timing
- Reset (`rst_n`=0 at a clock edge) sets:
  - all outputs 0, including `cmd_rdy_o`, data and key outputs, and the strobes;
  - state IDLE;
  - counter 0;
  - latched direction 0.
- Reset mid-message discards the message and the key. No `done_o`/`err_o` is emitted.
- Issue latency is 1 cycle: a command accepted at edge N drives its strobe and data during cycle N+1 (registered outputs).
- Back-to-back AAD/DATA/TAG are issued at 1 per cycle with no bubbles.
- `gcm_data_o`/`gcm_key_o` hold their last value when no strobe is active.
- The first AAD/DATA strobe is issued no earlier than `H_WAIT`+1 cycles after the IV strobe.
- `done_o`/`err_o` are registered: they appear 1 cycle after the triggering input.
- The next IV can be accepted the cycle after `done_o`.
- Simultaneous `gcm_tag_vld_i` and `gcm_ok_vld_i` in decrypt: done is issued in that same resolution cycle.
- Timeout and tag arriving in the same cycle: the tag wins (no error).

## Structure
- `gcm_pkg` holds:
  - `gcm_cmd_e`: KEY=0, IV=1, AAD=2, DATA=3, TAG=4, END=5; values 6–7 are illegal;
  - `gcm_seq_state_e`;
  - the default `KEY_WAIT`/`H_WAIT`/`DONE_TIMEOUT` constants.
- Single module. No sub-module; the counter is inline.

## Test plan
- Encrypt, KEY_WAIT=12, H_WAIT=24: KEY, IV, 2×AAD, 3×DATA, END → strobes in order; first AAD strobe exactly 25 cycles after the IV strobe. Tag response 5 cycles after END → `done_o`=1, `auth_ok_o`=1.
- Decrypt: IV, 1×DATA, TAG, END; model returns `gcm_ok_i`=0 → `done_o`=1, `auth_ok_o`=0. Repeat with `gcm_ok_i`=1 → `auth_ok_o`=1.
- Illegal order: DATA in KEYED → `err_o` pulse, no strobe. AAD after DATA → `err_o`, stay in DATA. TAG in encrypt → `err_o`. Type 7 → `err_o`.
- Back-to-back: `cmd_vld_i` held high with 8 DATA → 8 consecutive `gcm_data_vld_o` cycles, each carrying its own word. `cmd_rdy_o` stays 0 for the whole IV_SETTLE window.
- Timeout: END issued, model never asserts tag → `err_o` exactly 64 cycles later, state KEYED, next IV accepted.
- Reset mid-DATA: `rst_n`=0 for 1 cycle → all outputs 0, IV rejected (`err_o`) until a new KEY plus 12 cycles.
